// File: rtl/n64_poll_transmitter.sv
// N64 controller poll transmitter: serialises a command byte onto the open-drain
// data line, sends the stop bit, then waits for the controller's response edge.
//
// state     | meaning
// IDLE      | line released, waiting for start
// SEND      | shifting out the 8 command bits, MSB first
// STOP      | stop bit: 1 us low, 2 us released
// WAIT_RESP | line released, waiting for a synchronized falling edge or timeout
module n64_poll_transmitter #(
    parameter int CLKS_PER_US     = 12,
    parameter int RESP_TIMEOUT_US = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] command,
    input  logic       data_in,
    output logic       data_oe,
    output logic       busy,
    output logic       enable_latch,
    output logic       timeout
);

    localparam int US_MAX = (RESP_TIMEOUT_US > 4) ? RESP_TIMEOUT_US : 4;
    localparam int UW     = $clog2(US_MAX + 1);
    localparam int PW     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    localparam logic [PW-1:0] PRE_LAST     = PW'(CLKS_PER_US - 1);
    localparam logic [UW-1:0] US_BIT_LAST  = UW'(3);
    localparam logic [UW-1:0] US_STOP_LAST = UW'(2);
    localparam logic [UW-1:0] US_TO_LAST   = UW'(RESP_TIMEOUT_US - 1);

    typedef enum logic [1:0] {IDLE, SEND, STOP, WAIT_RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [UW-1:0]   us_q, us_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q, prev_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            el_q, el_d;
    logic            to_q, to_d;

    logic            us_tick;
    logic            fall;

    assign us_tick = (pre_q == PRE_LAST);
    assign fall    = prev_q & ~sync2_q;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        us_d    = us_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        el_d    = 1'b0;
        to_d    = 1'b0;
        sync1_d = data_in;
        sync2_d = sync1_q;
        // Edge history is only kept inside WAIT_RESP, so a line that is already
        // low on entry needs to be seen high before a fall can count.
        prev_d  = (state_q == WAIT_RESP) ? sync2_q : 1'b0;

        case (state_q)
            IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (start) begin
                    state_d = SEND;
                    shift_d = command;
                    idx_d   = 3'd7;
                end
            end
            SEND: begin
                if (us_tick) begin
                    pre_d = '0;
                    if (us_q == US_BIT_LAST) begin
                        us_d = '0;
                        if (idx_q == 3'd0) begin
                            state_d = STOP;
                        end else begin
                            idx_d   = idx_q - 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            STOP: begin
                if (us_tick) begin
                    pre_d = '0;
                    if (us_q == US_STOP_LAST) begin
                        us_d    = '0;
                        state_d = WAIT_RESP;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            WAIT_RESP: begin
                if (fall) begin
                    el_d    = 1'b1;
                    state_d = IDLE;
                    pre_d   = '0;
                    us_d    = '0;
                end else if (us_tick && (us_q == US_TO_LAST)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    pre_d   = '0;
                    us_d    = '0;
                end else if (us_tick) begin
                    pre_d = '0;
                    us_d  = us_q + 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is derived from where the counters will be next cycle so
        // the registered output lines up with the bit timing.
        case (state_d)
            SEND:    oe_d = shift_d[7] ? (us_d == '0) : (us_d != US_BIT_LAST);
            STOP:    oe_d = (us_d == '0);
            default: oe_d = 1'b0;
        endcase

        busy_d = (state_d != IDLE) || el_d || to_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            us_q    <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            el_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            us_q    <= us_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            el_q    <= el_d;
            to_q    <= to_d;
        end
    end

    assign data_oe      = oe_q;
    assign busy         = busy_q;
    assign enable_latch = el_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_n64_poll_transmitter.sv
// Self-checking bench for n64_poll_transmitter: per-cycle traces of every output
// are compared against a waveform model built from the command bits.
module tb_n64_poll_transmitter;

    localparam int C         = 4;
    localparam int TO        = 64;
    localparam int NK        = 400;
    localparam int SEND_STOP = 8 * 4 * C + 3 * C;
    localparam int TO_K      = SEND_STOP + TO * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] command = 8'h00;
    logic       data_in = 1'b1;
    logic       data_oe;
    logic       busy;
    logic       enable_latch;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    logic oe_tr[NK], busy_tr[NK], el_tr[NK], to_tr[NK];
    logic exp_oe[NK], exp_busy[NK], exp_el[NK], exp_to[NK];

    n64_poll_transmitter #(.CLKS_PER_US(C), .RESP_TIMEOUT_US(TO)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .command(command),
        .data_in(data_in),
        .data_oe(data_oe),
        .busy(busy),
        .enable_latch(enable_latch),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Cycle k is the cycle following the k-th clock edge after the start edge.
    task automatic build_expected(input logic [7:0] cmd, input int resp_k);
        int  k;
        int  hi;
        int  pulse_k;
        bit  is_el;
        k = 0;
        for (int b = 7; b >= 0; b--) begin
            hi = cmd[b] ? C : 3 * C;
            for (int j = 0; j < 4 * C; j++) begin
                exp_oe[k] = (j < hi);
                k++;
            end
        end
        for (int j = 0; j < 3 * C; j++) begin
            exp_oe[k] = (j < C);
            k++;
        end
        while (k < NK) begin
            exp_oe[k] = 1'b0;
            k++;
        end
        // A low driven in cycle r reaches the edge detector two edges later and
        // the pulse is registered one edge after that; the line must have been
        // sampled high inside the wait window first.
        is_el   = (resp_k >= SEND_STOP - 1) && (resp_k + 3 <= TO_K);
        pulse_k = is_el ? resp_k + 3 : TO_K;
        for (int i = 0; i < NK; i++) begin
            exp_el[i]   = is_el && (i == pulse_k);
            exp_to[i]   = !is_el && (i == pulse_k);
            exp_busy[i] = (i <= pulse_k);
        end
    endtask

    task automatic capture(input logic [7:0] cmd, input int resp_k, input bit noise);
        @(negedge clock);
        command = cmd;
        start   = 1'b1;
        data_in = 1'b1;
        @(posedge clock);
        for (int k = 0; k < NK; k++) begin
            @(negedge clock);
            oe_tr[k]   = data_oe;
            busy_tr[k] = busy;
            el_tr[k]   = enable_latch;
            to_tr[k]   = timeout;
            start = 1'b0;
            if (noise && k < 120) begin
                start   = 1'($urandom_range(0, 1));
                command = 8'($urandom);
                data_in = 1'($urandom_range(0, 1));
            end else if (noise && k == 120) begin
                data_in = 1'b1;
            end
            if (resp_k >= 0 && k >= resp_k) data_in = 1'b0;
        end
        start   = 1'b0;
        data_in = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_state();
        #2;
        checks++;
        if (data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b want=0", data_oe); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (enable_latch !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got el=%b to=%b want 0 0", enable_latch, timeout);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || data_oe !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b oe=%b want 0 0", busy, data_oe);
        end
    endtask

    task automatic test_directed();
        string      names[8] = '{"poll_timeout", "poll_response", "start_ignored_noise", "all_ones",
                                 "info_response", "low_on_entry", "tie_edge_wins", "timeout_just_before_edge"};
        logic [7:0] cmds[8]  = '{8'h01, 8'h01, 8'h01, 8'hFF, 8'h00, 8'h01, 8'hA5, 8'h5A};
        int         resps[8] = '{-1, 180, 200, 160, 300, 130, 393, 394};
        bit         noises[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 8; t++) begin
            int bad_oe, bad_busy, bad_el, bad_to, overlap;
            int f_oe, f_busy, f_el, f_to;
            bad_oe = 0; bad_busy = 0; bad_el = 0; bad_to = 0; overlap = 0;
            f_oe = 0; f_busy = 0; f_el = 0; f_to = 0;
            build_expected(cmds[t], resps[t]);
            capture(cmds[t], resps[t], noises[t]);
            for (int k = 0; k < NK; k++) begin
                if (oe_tr[k] !== exp_oe[k]) begin if (bad_oe == 0) f_oe = k; bad_oe++; end
                if (busy_tr[k] !== exp_busy[k]) begin if (bad_busy == 0) f_busy = k; bad_busy++; end
                if (el_tr[k] !== exp_el[k]) begin if (bad_el == 0) f_el = k; bad_el++; end
                if (to_tr[k] !== exp_to[k]) begin if (bad_to == 0) f_to = k; bad_to++; end
                if (el_tr[k] === 1'b1 && to_tr[k] === 1'b1) overlap++;
            end
            checks++;
            if (bad_oe != 0) begin failures++; $display("FAIL %s oe_pattern bad=%0d cycle=%0d got=%b want=%b", names[t], bad_oe, f_oe, oe_tr[f_oe], exp_oe[f_oe]); end
            checks++;
            if (bad_busy != 0) begin failures++; $display("FAIL %s busy bad=%0d cycle=%0d got=%b want=%b", names[t], bad_busy, f_busy, busy_tr[f_busy], exp_busy[f_busy]); end
            checks++;
            if (bad_el != 0) begin failures++; $display("FAIL %s enable_latch bad=%0d cycle=%0d got=%b want=%b", names[t], bad_el, f_el, el_tr[f_el], exp_el[f_el]); end
            checks++;
            if (bad_to != 0) begin failures++; $display("FAIL %s timeout bad=%0d cycle=%0d got=%b want=%b", names[t], bad_to, f_to, to_tr[f_to], exp_to[f_to]); end
            checks++;
            if (overlap != 0) begin failures++; $display("FAIL %s pulse_overlap got=%0d cycles want=0", names[t], overlap); end
        end
    endtask

    task automatic test_reset_mid_send();
        build_expected(8'h00, -1);
        @(negedge clock);
        command = 8'h00;
        start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        checks++;
        if (data_oe !== exp_oe[40]) begin failures++; $display("FAIL mid_send_oe_before_reset got=%b want=%b", data_oe, exp_oe[40]); end
        reset = 1'b1;
        #1;
        checks++;
        if (data_oe !== 1'b0) begin failures++; $display("FAIL mid_send_reset_oe got=%b want=0", data_oe); end
        checks++;
        if (busy !== 1'b0 || enable_latch !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL mid_send_reset_outputs got busy=%b el=%b to=%b want 0 0 0", busy, enable_latch, timeout);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || data_oe !== 1'b0) begin
            failures++;
            $display("FAIL mid_send_post_reset_idle got busy=%b oe=%b want 0 0", busy, data_oe);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            logic [7:0] cmd;
            int resp_k, bad_oe, bad_busy, bad_el, bad_to, overlap, f_oe, f_el, f_to;
            bit noise;
            cmd    = 8'($urandom);
            resp_k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(150, 390));
            noise  = 1'($urandom_range(0, 1));
            bad_oe = 0; bad_busy = 0; bad_el = 0; bad_to = 0; overlap = 0;
            f_oe = 0; f_el = 0; f_to = 0;
            build_expected(cmd, resp_k);
            capture(cmd, resp_k, noise);
            for (int k = 0; k < NK; k++) begin
                if (oe_tr[k] !== exp_oe[k]) begin if (bad_oe == 0) f_oe = k; bad_oe++; end
                if (busy_tr[k] !== exp_busy[k]) bad_busy++;
                if (el_tr[k] !== exp_el[k]) begin if (bad_el == 0) f_el = k; bad_el++; end
                if (to_tr[k] !== exp_to[k]) begin if (bad_to == 0) f_to = k; bad_to++; end
                if (el_tr[k] === 1'b1 && to_tr[k] === 1'b1) overlap++;
            end
            checks++;
            if (bad_oe != 0) begin failures++; $display("FAIL rand%0d cmd=%h oe_pattern bad=%0d cycle=%0d got=%b want=%b", t, cmd, bad_oe, f_oe, oe_tr[f_oe], exp_oe[f_oe]); end
            checks++;
            if (bad_busy != 0) begin failures++; $display("FAIL rand%0d busy bad=%0d cycles want=0", t, bad_busy); end
            checks++;
            if (bad_el != 0) begin failures++; $display("FAIL rand%0d resp=%0d enable_latch cycle=%0d got=%b want=%b", t, resp_k, f_el, el_tr[f_el], exp_el[f_el]); end
            checks++;
            if (bad_to != 0) begin failures++; $display("FAIL rand%0d resp=%0d timeout cycle=%0d got=%b want=%b", t, resp_k, f_to, to_tr[f_to], exp_to[f_to]); end
            checks++;
            if (overlap != 0) begin failures++; $display("FAIL rand%0d pulse_overlap got=%0d want=0", t, overlap); end
        end
    endtask

    initial begin
        test_reset_state();
        test_directed();
        test_reset_mid_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n64_poll_transmitter.md
N64_POLL_TRANSMITTER -- requirements
Module: n64_poll_transmitter

Interface
REQ-001 The module SHALL have parameter CLKS_PER_US, default 12, giving clock cycles per microsecond.
REQ-002 The module SHALL have parameter RESP_TIMEOUT_US, default 64, giving the response wait limit in microseconds.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all logic rises on posedge clock.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: transaction request, sampled in IDLE only.
REQ-006 The module SHALL have port command, input, 8 bits: command byte, e.g. 8'h01 poll, 8'h00 info, 8'hFF reset.
REQ-007 The module SHALL have port data_in, input, 1 bit: raw level of the controller data line, asynchronous.
REQ-008 The module SHALL have port data_oe, output, 1 bit: 1 pulls the open-drain line low; 0 releases it.
REQ-009 The module SHALL have port busy, output, 1 bit: transaction in progress.
REQ-010 The module SHALL have port enable_latch, output, 1 bit: one-cycle pulse at controller response start; it arms the serial-to-parallel receiver.
REQ-011 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when no response arrives.

Function
REQ-012 States SHALL be IDLE, SEND, STOP and WAIT_RESP.
REQ-013 In IDLE with start=1, command SHALL be latched into an internal shift register, bit index SHALL be set to 7, and the next state SHALL be SEND; start in any other state SHALL be ignored.
REQ-014 data_oe SHALL rise on the clock edge that leaves IDLE, giving 1 cycle of latency from start.
REQ-015 Each command bit SHALL last 4*CLKS_PER_US cycles, sent MSB first.
REQ-016 Bit 0 SHALL drive data_oe=1 for 3*CLKS_PER_US cycles, then 0 for CLKS_PER_US cycles.
REQ-017 Bit 1 SHALL drive data_oe=1 for CLKS_PER_US cycles, then 0 for 3*CLKS_PER_US cycles.
REQ-018 Timing SHALL use a prescaler counting 0..CLKS_PER_US-1 and a microsecond counter 0..3 within each bit; both SHALL reset at every bit boundary.
REQ-019 After bit index 0 completes, the state SHALL be STOP, which drives data_oe=1 for CLKS_PER_US cycles, then 0 for 2*CLKS_PER_US cycles, then enters WAIT_RESP.
REQ-020 data_in SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be ignored outside WAIT_RESP.
REQ-021 In WAIT_RESP, data_oe SHALL be 0.
REQ-022 In WAIT_RESP, a synchronized 1->0 transition SHALL pulse enable_latch for exactly one cycle and return the state to IDLE.
REQ-023 In WAIT_RESP, if RESP_TIMEOUT_US microseconds elapse with no falling edge, timeout SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-024 If a falling edge and timeout expiry occur on the same cycle, enable_latch SHALL win and timeout SHALL stay 0.
REQ-025 A synchronized line already low on entry to WAIT_RESP SHALL NOT count as an edge; a high-then-low transition SHALL be required.
REQ-026 busy SHALL be 1 from the cycle after start is accepted through the cycle enable_latch or timeout pulses, and 0 in IDLE.
REQ-027 enable_latch and timeout SHALL never be 1 on the same cycle.
REQ-028 The microsecond counter SHALL be sized for max(4, RESP_TIMEOUT_US) without wrap.
REQ-029 The bit index SHALL NOT wrap below 0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE; data_oe=0; busy=0; enable_latch=0; timeout=0; all counters, shift register and synchronizer flops=0/1 as follows: counters 0, synchronizer flops 1 (line idle high).
REQ-032 Reset asserted mid-transaction SHALL release the line (data_oe=0) without waiting for a clock edge.
REQ-033 After reset deasserts, the first start SHALL behave as in REQ-013.

Verification (CLKS_PER_US=4, RESP_TIMEOUT_US=64)
REQ-034 Reset pulse mid-SEND -> data_oe=0 immediately; busy=0, enable_latch=0, timeout=0 the same cycle.
REQ-035 command=8'h01, one-cycle start, data_in=1 -> data_oe pattern: seven times (12 cycles 1, 4 cycles 0), then 4 cycles 1 / 12 cycles 0, then stop 4 cycles 1 / 8 cycles 0; SEND+STOP total 140 cycles.
REQ-036 As REQ-035 with data_in held 1 -> timeout pulses once, 256 cycles after entering WAIT_RESP; busy=0 the next cycle.
REQ-037 As REQ-035, with data_in driven 0 40 cycles into WAIT_RESP -> enable_latch pulses once, 2-3 cycles after the fall; timeout stays 0.
REQ-038 start re-pulsed during SEND and data_in toggled during SEND -> the transmitted pattern is unchanged and no enable_latch pulse occurs.
REQ-039 command=8'hFF -> eight bits of 4 cycles 1 / 12 cycles 0, then stop as in REQ-035.
